// File: rtl/cheat_pkg.sv
// Shared constants, table entry type and character decode for cheat_code_bank.
// CHEAT_COMPARE_EN adds a ROM compare byte to every code (7 characters per slot).
package cheat_pkg;

    localparam logic [7:0] CHAR_BLANK     = 8'h02;
    localparam logic [7:0] CHAR_DIGIT_MIN = 8'h04;
    localparam logic [7:0] CHAR_DIGIT_MAX = 8'h22;

`ifdef CHEAT_COMPARE_EN
    localparam int CODE_CHARS_CFG = 7;
`else
    localparam int CODE_CHARS_CFG = 5;
`endif

    typedef struct packed {
        logic        valid;
        logic [12:0] addr;
        logic [7:0]  data;
        logic [7:0]  cmp;
    } cheat_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } scan_state_t;

    // {illegal, digit}; digit = (ch >> 1) - 2, and only its low nibble matters.
    function automatic logic [4:0] decodeChar(input logic [7:0] ch);
        logic       bad;
        logic [3:0] digit;
        bad   = (ch < CHAR_DIGIT_MIN) || (ch > CHAR_DIGIT_MAX) || ch[0];
        digit = ch[4:1] - 4'd2;
        return {bad, digit};
    endfunction

endpackage

// File: rtl/cheat_code_bank_if.sv
// Cartridge bus lookup path: the cartridge side drives address/ROM byte,
// the cheat bank answers with a registered override.
interface cheat_bus_if;
    logic [12:0] cartAddress;
    logic [7:0]  romData;
    logic        dataOverride;
    logic [7:0]  overrideData;

    modport master (
        output cartAddress, romData,
        input  dataOverride, overrideData
    );

    modport slave (
        input  cartAddress, romData,
        output dataOverride, overrideData
    );
endinterface

// File: rtl/cheat_char_decoder.sv
// On-screen character -> blank / illegal / hex digit. Purely combinational.
module cheat_char_decoder
    import cheat_pkg::*;
(
    input  logic [7:0] ch,
    output logic       blank,
    output logic       illegal,
    output logic [3:0] digit
);
    logic [4:0] dec;

    assign dec     = decodeChar(ch);
    assign blank   = (ch == CHAR_BLANK);
    assign illegal = dec[4] && !blank;
    assign digit   = dec[3:0];
endmodule

// File: rtl/cheat_code_bank.sv
// Multi-slot cheat bank: scans the on-screen character buffer into a patch table
// and overrides matching cartridge reads one cycle later. Option: CHEAT_COMPARE_EN.
module cheat_code_bank
    import cheat_pkg::*;
#(
    parameter int NUM_CODES  = 3,
    parameter int CODE_CHARS = CODE_CHARS_CFG,
    parameter bit RESCAN     = 1'b1
) (
    input  logic                              CLOCK_50,
    input  logic                              reset,
    input  logic                              showCheatUI,
    input  logic [NUM_CODES*CODE_CHARS*8-1:0] cheatDigits,
    cheat_bus_if.slave                        bus,
    output logic [NUM_CODES-1:0]              codeValid,
    output logic                              scanBusy
);
    localparam int TOTAL_CHARS = NUM_CODES * CODE_CHARS;
    localparam int SLOT_W      = (NUM_CODES > 1) ? $clog2(NUM_CODES) : 1;
    localparam int CHAR_W      = $clog2(CODE_CHARS);
    localparam int CIDX_W      = $clog2(TOTAL_CHARS);
    localparam int SHADOW_W    = 4 * CODE_CHARS;

    scan_state_t          state;
    logic [SLOT_W-1:0]    slotIdx;
    logic [CHAR_W-1:0]    charIdx;
    logic [SHADOW_W-1:0]  shadow;
    logic                 bad;
    logic                 showPrev;
    cheat_entry_t         tbl [NUM_CODES];
    cheat_entry_t         newEntry;

    logic [7:0]           charArr [TOTAL_CHARS];
    logic [CIDX_W-1:0]    charSel;
    logic [7:0]           curChar;
    logic                 chBlank;
    logic                 chIllegal;
    logic [3:0]           chDigit;

    logic                 startPass;
    logic                 lastChar;
    logic                 lastSlot;

    logic [NUM_CODES-1:0] slotMatch;
    logic                 hit;
    logic [7:0]           hitData;

    for (genvar k = 0; k < TOTAL_CHARS; k++) begin : g_chars
        assign charArr[k] = cheatDigits[k*8 +: 8];
    end

    assign charSel = CIDX_W'(32'(slotIdx) * CODE_CHARS + 32'(charIdx));
    assign curChar = charArr[charSel];

    cheat_char_decoder u_dec (
        .ch      (curChar),
        .blank   (chBlank),
        .illegal (chIllegal),
        .digit   (chDigit)
    );

    assign startPass = showCheatUI && (RESCAN || !showPrev);
    assign lastChar  = (charIdx == CHAR_W'(CODE_CHARS - 1));
    assign lastSlot  = (slotIdx == SLOT_W'(NUM_CODES - 1));

    // Shadow holds d0 in its top nibble once all characters have shifted in.
    always_comb begin
        newEntry       = '0;
        newEntry.valid = !bad;
        newEntry.addr  = {1'b1, shadow[SHADOW_W-1 -: 12]};
        newEntry.data  = shadow[SHADOW_W-13 -: 8];
`ifdef CHEAT_COMPARE_EN
        newEntry.cmp   = shadow[SHADOW_W-21 -: 8];
`endif
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= IDLE;
            slotIdx  <= '0;
            charIdx  <= '0;
            shadow   <= '0;
            bad      <= 1'b0;
            showPrev <= 1'b0;
            scanBusy <= 1'b0;
            for (int i = 0; i < NUM_CODES; i++) tbl[i] <= '0;
        end else begin
            showPrev <= showCheatUI;
            unique case (state)
                IDLE: begin
                    if (startPass) begin
                        state    <= SCAN;
                        scanBusy <= 1'b1;
                        slotIdx  <= '0;
                        charIdx  <= '0;
                        bad      <= 1'b0;
                    end
                end
                SCAN: begin
                    // UI closed mid-slot: drop the partial slot, keep the table.
                    if (!showCheatUI) begin
                        state    <= IDLE;
                        scanBusy <= 1'b0;
                        slotIdx  <= '0;
                        charIdx  <= '0;
                        bad      <= 1'b0;
                    end else begin
                        shadow <= {shadow[SHADOW_W-5:0], chDigit};
                        bad    <= bad | chBlank | chIllegal;
                        if (lastChar) begin
                            state   <= COMMIT;
                            charIdx <= '0;
                        end else begin
                            charIdx <= charIdx + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    tbl[slotIdx] <= newEntry;
                    bad          <= 1'b0;
                    if (!showCheatUI || (lastSlot && !RESCAN)) begin
                        state    <= IDLE;
                        scanBusy <= 1'b0;
                        slotIdx  <= '0;
                    end else begin
                        state   <= SCAN;
                        slotIdx <= lastSlot ? '0 : slotIdx + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    scanBusy <= 1'b0;
                end
            endcase
        end
    end

    for (genvar s = 0; s < NUM_CODES; s++) begin : g_slot
        assign codeValid[s] = tbl[s].valid;
`ifdef CHEAT_COMPARE_EN
        assign slotMatch[s] = tbl[s].valid && (tbl[s].addr == bus.cartAddress)
                              && (tbl[s].cmp == bus.romData);
`else
        assign slotMatch[s] = tbl[s].valid && (tbl[s].addr == bus.cartAddress);
        logic unusedCmp;
        assign unusedCmp = ^tbl[s].cmp;
`endif
    end

`ifndef CHEAT_COMPARE_EN
    logic unusedRom;
    assign unusedRom = ^bus.romData;
`endif

    // Walk high to low so the lowest matching slot is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hitData = '0;
        for (int i = NUM_CODES - 1; i >= 0; i--) begin
            if (slotMatch[i]) begin
                hit     = 1'b1;
                hitData = tbl[i].data;
            end
        end
    end

    // Reads the table before any same-cycle COMMIT lands.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            bus.dataOverride <= 1'b0;
            bus.overrideData <= '0;
        end else begin
            bus.dataOverride <= hit;
            bus.overrideData <= hitData;
        end
    end

endmodule

// File: tb/tb_cheat_code_bank.sv
// Scoreboard bench for cheat_code_bank: lookups push expectations, a negedge
// monitor pops and compares them one cycle after the address is presented.
module tb_cheat_code_bank;
    import cheat_pkg::*;

    localparam int NC    = 3;
    localparam int CC    = CODE_CHARS_CFG;
    localparam int TOT   = NC * CC;
    localparam int PASS  = NC * (CC + 1);

    logic              CLOCK_50 = 1'b0;
    logic              reset;
    logic              showCheatUI;
    logic [TOT*8-1:0]  cheatDigits;
    logic [NC-1:0]     codeValid;
    logic              scanBusy;
    logic [7:0]        charBuf [TOT];

    cheat_bus_if bus ();

    cheat_code_bank #(.NUM_CODES(NC), .CODE_CHARS(CC), .RESCAN(1'b1)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .showCheatUI (showCheatUI),
        .cheatDigits (cheatDigits),
        .bus         (bus),
        .codeValid   (codeValid),
        .scanBusy    (scanBusy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    for (genvar k = 0; k < TOT; k++) begin : g_buf
        assign cheatDigits[k*8 +: 8] = charBuf[k];
    end

    typedef struct {
        logic       ov;
        logic [7:0] data;
        int         due;
        string      tag;
    } exp_t;

    exp_t sbQ[$];
    int   cycle    = 0;
    int   checks   = 0;
    int   failures = 0;

    initial forever begin
        @(posedge CLOCK_50);
        cycle++;
    end

    initial forever begin
        exp_t e;
        @(negedge CLOCK_50);
        while (sbQ.size() > 0 && sbQ[0].due <= cycle) begin
            e = sbQ.pop_front();
            checks++;
            if (bus.dataOverride !== e.ov || (e.ov && bus.overrideData !== e.data)) begin
                failures++;
                $display("FAIL %s: dataOverride=%0b overrideData=%02h, expected %0b/%02h",
                         e.tag, bus.dataOverride, bus.overrideData, e.ov, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic issue(input logic [12:0] a, input logic [7:0] r, input logic ov,
                         input logic [7:0] d, input string tag);
        bus.cartAddress = a;
        bus.romData     = r;
        sbQ.push_back('{ov, d, cycle + 1, tag});
        tick();
    endtask

    task automatic blankAll();
        for (int k = 0; k < TOT; k++) charBuf[k] = CHAR_BLANK;
    endtask

    // Encode 3 address digits, data byte and compare byte as on-screen characters.
    task automatic setSlot(input int s, input logic [11:0] a, input logic [7:0] d,
                           input logic [7:0] c);
        logic [27:0] nib;
        logic [3:0]  n;
        nib = {a, d, c};
        for (int k = 0; k < CC; k++) begin
            n = nib[27 - 4*k -: 4];
            charBuf[s*CC + k] = (8'(n) + 8'd2) << 1;
        end
    endtask

    task automatic runPass();
        showCheatUI = 1'b1;
        repeat (PASS + 3) tick();
        showCheatUI = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        checks += 4;
        if (bus.dataOverride !== 1'b0) begin failures++; $display("FAIL reset_ov: got %0b want 0", bus.dataOverride); end
        if (bus.overrideData !== 8'h00) begin failures++; $display("FAIL reset_data: got %02h want 00", bus.overrideData); end
        if (codeValid !== 3'b000) begin failures++; $display("FAIL reset_valid: got %b want 000", codeValid); end
        if (scanBusy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", scanBusy); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        blankAll();
        setSlot(0, 12'h1F0, 8'hA5, 8'h3C);
        charBuf[0] = 8'h06; charBuf[1] = 8'h22; charBuf[2] = 8'h04;
        charBuf[3] = 8'h18; charBuf[4] = 8'h0E;
        showCheatUI = 1'b1;
        repeat (3) tick();
        checks++;
        if (scanBusy !== 1'b1) begin failures++; $display("FAIL single_busy: got %0b want 1", scanBusy); end
        repeat (PASS) tick();
        showCheatUI = 1'b0;
        repeat (2) tick();
        checks++;
        if (codeValid !== 3'b001) begin failures++; $display("FAIL single_valid: got %b want 001", codeValid); end
        issue(13'h11F0, 8'h3C, 1'b1, 8'hA5, "single_hit");
        issue(13'h11F1, 8'h3C, 1'b0, 8'h00, "single_miss");
        issue(13'h01F0, 8'h3C, 1'b0, 8'h00, "single_bit12");
    endtask

    task automatic test_illegal();
        blankAll();
        setSlot(0, 12'h123, 8'h45, 8'h3C);
        setSlot(1, 12'h789, 8'hAB, 8'h3C);
        charBuf[1*CC + 1] = 8'h07;
        setSlot(2, 12'hABC, 8'h66, 8'h3C);
        runPass();
        checks++;
        if (codeValid !== 3'b101) begin failures++; $display("FAIL illegal_valid: got %b want 101", codeValid); end
        issue(13'h1789, 8'h3C, 1'b0, 8'h00, "illegal_slot1");
        issue(13'h1123, 8'h3C, 1'b1, 8'h45, "illegal_slot0");
        issue(13'h1ABC, 8'h3C, 1'b1, 8'h66, "illegal_slot2");
    endtask

    task automatic test_priority();
        blankAll();
        setSlot(0, 12'h123, 8'h11, 8'h3C);
        setSlot(1, 12'h456, 8'h33, 8'h3C);
        setSlot(2, 12'h123, 8'h22, 8'h3C);
        runPass();
        checks++;
        if (codeValid !== 3'b111) begin failures++; $display("FAIL prio_valid: got %b want 111", codeValid); end
        issue(13'h1123, 8'h3C, 1'b1, 8'h11, "prio_lowest");
        issue(13'h1456, 8'h3C, 1'b1, 8'h33, "prio_slot1");
        issue(13'h1123, 8'h3C, 1'b1, 8'h11, "prio_again");
    endtask

    task automatic test_drop_midpass();
        blankAll();
        setSlot(0, 12'h200, 8'h01, 8'h3C);
        setSlot(1, 12'h300, 8'h02, 8'h3C);
        setSlot(2, 12'h456, 8'h77, 8'h3C);
        runPass();
        setSlot(2, 12'h789, 8'h88, 8'h3C);
        showCheatUI = 1'b1;
        repeat (15) tick();
        checks++;
        if (scanBusy !== 1'b1) begin failures++; $display("FAIL drop_busy_before: got %0b want 1", scanBusy); end
        showCheatUI = 1'b0;
        tick();
        checks += 2;
        if (scanBusy !== 1'b0) begin failures++; $display("FAIL drop_busy_after: got %0b want 0", scanBusy); end
        if (codeValid !== 3'b111) begin failures++; $display("FAIL drop_valid: got %b want 111", codeValid); end
        issue(13'h1456, 8'h3C, 1'b1, 8'h77, "drop_slot2_old");
        issue(13'h1789, 8'h3C, 1'b0, 8'h00, "drop_slot2_new");
        issue(13'h1200, 8'h3C, 1'b1, 8'h01, "drop_slot0");
        issue(13'h1300, 8'h3C, 1'b1, 8'h02, "drop_slot1");
    endtask

    task automatic test_reset_midscan();
        bus.cartAddress = 13'h1200;
        bus.romData     = 8'h3C;
        showCheatUI     = 1'b1;
        repeat (8) tick();
        checks += 2;
        if (scanBusy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_pre: got %0b want 1", scanBusy); end
        if (bus.dataOverride !== 1'b1) begin failures++; $display("FAIL rst_mid_ov_pre: got %0b want 1", bus.dataOverride); end
        reset = 1'b1;
        tick();
        checks += 4;
        if (scanBusy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %0b want 0", scanBusy); end
        if (bus.dataOverride !== 1'b0) begin failures++; $display("FAIL rst_mid_ov: got %0b want 0", bus.dataOverride); end
        if (bus.overrideData !== 8'h00) begin failures++; $display("FAIL rst_mid_data: got %02h want 00", bus.overrideData); end
        if (codeValid !== 3'b000) begin failures++; $display("FAIL rst_mid_valid: got %b want 000", codeValid); end
        showCheatUI = 1'b0;
        reset       = 1'b0;
        tick();
        issue(13'h1200, 8'h3C, 1'b0, 8'h00, "rst_mid_cleared");
    endtask

`ifdef CHEAT_COMPARE_EN
    task automatic test_compare();
        blankAll();
        setSlot(0, 12'h1F0, 8'hA5, 8'h3C);
        runPass();
        issue(13'h11F0, 8'h3C, 1'b1, 8'hA5, "cmp_match");
        issue(13'h11F0, 8'h3D, 1'b0, 8'h00, "cmp_mismatch");
    endtask
`endif

    initial begin
        reset           = 1'b1;
        showCheatUI     = 1'b0;
        bus.cartAddress = '0;
        bus.romData     = '0;
        blankAll();

        test_reset();
        test_single();
        test_illegal();
        test_priority();
        test_drop_midpass();
        test_reset_midscan();
`ifdef CHEAT_COMPARE_EN
        test_compare();
`endif
        repeat (3) tick();
        checks++;
        if (sbQ.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sbQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cheat_code_bank.md
Name: cheat_code_bank

Overview:
- Multi-slot successor to the single cheat-code decoder; replaces per-startIndex combinational slicing.
- A sequential scanner walks the on-screen cheat character buffer one character per clock, validates and decodes each slot, and loads a registered table of address/data patches.
- A registered lookup port sits on the cartridge bus path. It matches the current cartridge address against all valid slots and drives override data to the bus multiplexer.

Parameters:
- NUM_CODES, 3, number of cheat slots. Total characters = NUM_CODES*CODE_CHARS.
- CODE_CHARS, 5, characters per slot: 3 address digits + 2 data digits. Becomes 7 when CHEAT_COMPARE_EN is defined.
- RESCAN, 1, 1 = scan continuously while the UI is shown; 0 = one pass per rising edge of showCheatUI.

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- showCheatUI  in  1  cheat UI active; scanning is enabled only while high.
- cheatDigits  in  NUM_CODES*CODE_CHARS*8  character buffer; character k = bits [k*8 +: 8].
- cartAddress  in  13  current cartridge bus address.
- romData  in  8  original ROM byte; used only with CHEAT_COMPARE_EN.
- dataOverride  out  1  a valid slot matches; substitute overrideData.
- overrideData  out  8  replacement byte.
- codeValid  out  NUM_CODES  per-slot valid flags.
- scanBusy  out  1  scan pass in progress.

Behaviour:
- Reset values: all outputs 0; table cleared (every valid bit 0); FSM in IDLE; slot and character counters 0.
- Character decode:
  - 8'h02 is blank.
  - Even values 8'h04..8'h22 are digits: digit = (c>>1) - 2, range 0..F.
  - Any other value is illegal.
- FSM states: IDLE, SCAN, COMMIT.
  - IDLE -> SCAN when showCheatUI=1. With RESCAN=0, only on a rising edge of showCheatUI.
  - SCAN consumes one character per cycle. It shifts 4-bit digits into a slot shadow register and ORs a per-slot bad flag on blank or illegal characters.
  - After the last character of a slot, the FSM goes to COMMIT for one cycle, then advances to the next slot.
  - COMMIT writes the table entry:
    - address = {1'b1, d0, d1, d2}
    - data = {d3, d4}
    - valid = !bad
  - A slot with any blank or illegal character invalidates that slot only; other slots are unaffected.
  - After the last slot commits, the FSM returns to IDLE (RESCAN=0) or starts again at slot 0 (RESCAN=1).
  - Pass length = NUM_CODES*(CODE_CHARS+1) cycles.
- scanBusy is 1 in SCAN and COMMIT.
- showCheatUI dropping mid-pass: the partial slot is discarded and not committed, the FSM goes to IDLE, and already-committed entries are retained.
- Table contents persist while showCheatUI=0; gameplay uses the frozen table.
- Lookup latency is 1 cycle:
  - The registered dataOverride/overrideData at cycle n+1 reflect cartAddress at cycle n.
  - Match condition: valid && (address == cartAddress).
  - When several slots match, the lowest slot index wins.
- COMMIT in the same cycle as a lookup: the lookup uses the pre-write table; the new entry is visible from the next cycle.
- codeValid is driven directly by the table valid bits.

Optional Feature:
- Macro: CHEAT_COMPARE_EN.
- Defined:
  - CODE_CHARS becomes 7; digits d5,d6 form a compare byte.
  - Match additionally requires romData == {d5,d6}, with romData sampled in the same cycle as cartAddress.
- Undefined: no compare storage; romData is ignored.

Decomposition:
- Package cheat_pkg contains:
  - character constants: CHAR_BLANK=8'h02, CHAR_DIGIT_MIN=8'h04, CHAR_DIGIT_MAX=8'h22
  - a function mapping a character to {illegal, digit[3:0]}
  - the cheat_entry_t struct {valid, addr[12:0], data[7:0], cmp[7:0]}
- Sub-module cheat_char_decoder: combinational, character -> {blank, illegal, digit}. Instantiated once in the scanner datapath.

Test Plan:
- Characters 06,22,04,18,0E in slot 0, other slots blank, showCheatUI=1 for one pass:
  - codeValid=3'b001
  - with cartAddress=13'h11F0: dataOverride=1 and overrideData=8'hA5 one cycle later.
  - with cartAddress=13'h11F1: dataOverride=0.
- Slot 1 contains 8'h07 (illegal), slots 0 and 2 are valid codes: codeValid=3'b101; slot 1 never matches.
- Slots 0 and 2 both encode address 13'h1123, data 8'h11 and 8'h22: overrideData=8'h11 (lowest index wins).
- Drop showCheatUI during a slot-2 character:
  - slot 2 keeps its previous value
  - scanBusy falls the next cycle
  - slots 0 and 1 are retained.
- Assert reset mid-scan: all outputs and codeValid are 0 the next cycle; FSM in IDLE.
- With CHEAT_COMPARE_EN defined, code 1F0A5 with compare 3C:
  - override only when romData=8'h3C at cartAddress=13'h11F0
  - no override with romData=8'h3D.
